// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package pc_fetch_ctrl_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INCR          = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_SQUASH = 2'd2,
        ST_VALID  = 2'd3
    } fetch_state_e;

    // Word-align an address by clearing the byte-offset bits.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory request/response bus between the fetch controller and memory.
interface pc_fetch_ctrl_if;
    import pc_fetch_ctrl_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_target_sel.sv
// Redirect target selection: priority jump > jr > branch, word alignment and misalignment flag.
module pc_target_sel
    import pc_fetch_ctrl_pkg::*;
(
    input  logic            jump_i,
    input  logic            jr_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] pc_j_i,
    input  logic [XLEN-1:0] pc_r_i,
    input  logic [XLEN-1:0] pc_b_i,
    output logic            redirect_c_o,
    output logic [XLEN-1:0] target_c_o,
    output logic            misalign_c_o
);

    logic [XLEN-1:0] raw_target_c;

    always_comb begin
        raw_target_c = pc_b_i;
        if (jump_i) begin
            raw_target_c = pc_j_i;
        end else if (jr_i) begin
            raw_target_c = pc_r_i;
        end
    end

    assign redirect_c_o = jump_i | jr_i | branch_i;
    assign target_c_o   = word_align(raw_target_c);
    assign misalign_c_o = |raw_target_c[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Instruction fetch controller: issues fetches, squashes stale returns on redirect, holds the instruction.
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  PC_B,
    input  logic             jump,
    input  logic [XLEN-1:0]  PC_J,
    input  logic             jr,
    input  logic [XLEN-1:0]  PC_R,
    pc_fetch_ctrl_if.master  imem,
    output logic [XLEN-1:0]  instr,
    output logic             instr_valid,
    output logic [XLEN-1:0]  PC,
    output logic [XLEN-1:0]  PC_plus4,
    output logic             addr_err
);

    fetch_state_e    state_q;
    logic            req_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] instr_q;
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_plus4_q;
    logic            err_q;
    logic [XLEN-1:0] tgt_q;

    logic            redirect_c;
    logic [XLEN-1:0] target_c;
    logic            misalign_c;

    pc_target_sel u_target_sel (
        .jump_i       (jump),
        .jr_i         (jr),
        .branch_i     (branch_taken),
        .pc_j_i       (PC_J),
        .pc_r_i       (PC_R),
        .pc_b_i       (PC_B),
        .redirect_c_o (redirect_c),
        .target_c_o   (target_c),
        .misalign_c_o (misalign_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            instr_q    <= '0;
            valid_q    <= 1'b0;
            pc_q       <= RESET_PC;
            pc_plus4_q <= RESET_PC + PC_INCR;
            err_q      <= 1'b0;
            tgt_q      <= '0;
        end else begin
            // Any redirect outside IDLE is accepted, so the error pulse follows it directly.
            err_q <= (state_q != ST_IDLE) && redirect_c && misalign_c;

            unique case (state_q)
                ST_IDLE: begin
                    state_q <= ST_FETCH;
                    req_q   <= 1'b1;
                    addr_q  <= RESET_PC;
                end
                ST_FETCH: begin
                    if (imem.imem_ack && !redirect_c) begin
                        instr_q    <= imem.imem_rdata;
                        pc_q       <= addr_q;
                        pc_plus4_q <= addr_q + PC_INCR;
                        valid_q    <= 1'b1;
                        req_q      <= 1'b0;
                        state_q    <= ST_VALID;
                    end else if (imem.imem_ack) begin
                        addr_q <= target_c;
                    end else if (redirect_c) begin
                        tgt_q   <= target_c;
                        state_q <= ST_SQUASH;
                    end
                end
                ST_SQUASH: begin
                    // Outstanding fetch is stale; wait out its ack with the address held.
                    if (imem.imem_ack) begin
                        addr_q  <= redirect_c ? target_c : tgt_q;
                        state_q <= ST_FETCH;
                    end else if (redirect_c) begin
                        tgt_q <= target_c;
                    end
                end
                ST_VALID: begin
                    if (redirect_c || !stall) begin
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        addr_q  <= redirect_c ? target_c : pc_plus4_q;
                        state_q <= ST_FETCH;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign PC             = pc_q;
    assign PC_plus4       = pc_plus4_q;
    assign addr_err       = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic        jump;
    logic        jr;
    logic [31:0] PC_B;
    logic [31:0] PC_J;
    logic [31:0] PC_R;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PC_plus4;
    logic        addr_err;

    pc_fetch_ctrl_if imem ();

    pc_fetch_ctrl #(.RESET_PC(RPC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .PC_B         (PC_B),
        .jump         (jump),
        .PC_J         (PC_J),
        .jr           (jr),
        .PC_R         (PC_R),
        .imem         (imem),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .PC           (PC),
        .PC_plus4     (PC_plus4),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: a fetch is either outstanding (possibly doomed by a later redirect) or an instruction is held.
    logic        m_started, m_busy, m_have, m_drop, m_err;
    logic [31:0] m_addr, m_instr, m_pc, m_pc4, m_tgt;
    int          m_wait;
    int          dly;
    bit          ack_force, junk;
    logic [31:0] seq_q[$];

    function automatic void model_update();
        logic        red;
        logic [31:0] t;
        if (!rst_n) begin
            m_started = 0; m_busy = 0; m_have = 0; m_drop = 0; m_err = 0;
            m_addr = RPC; m_instr = 0; m_pc = RPC; m_pc4 = RPC + 32'd4; m_wait = 0;
            return;
        end
        if (!m_started) begin
            m_started = 1; m_busy = 1; m_addr = RPC; m_wait = 0; m_err = 0;
            return;
        end
        red   = jump | jr | branch_taken;
        t     = jump ? PC_J : (jr ? PC_R : PC_B);
        m_err = red && (t % 4 != 0);
        t     = t - (t % 4);
        if (m_busy) begin
            if (imem.imem_ack) begin
                if (red) begin
                    m_addr = t; m_drop = 0; m_wait = 0;
                end else if (m_drop) begin
                    m_addr = m_tgt; m_drop = 0; m_wait = 0;
                end else begin
                    m_busy = 0; m_have = 1; m_instr = imem.imem_rdata;
                    m_pc = m_addr; m_pc4 = m_addr + 32'd4;
                end
            end else begin
                m_wait++;
                if (red) begin
                    m_drop = 1; m_tgt = t;
                end
            end
        end else if (red) begin
            m_have = 0; m_busy = 1; m_addr = t; m_wait = 0;
        end else if (!stall) begin
            m_have = 0; m_busy = 1; m_addr = m_pc + 32'd4; m_wait = 0;
        end
    endfunction

    task automatic compare_all();
        chk("req",   32'(imem.imem_req), 32'(m_busy));
        chk("addr",  imem.imem_addr,     m_addr);
        chk("valid", 32'(instr_valid),   32'(m_have));
        chk("instr", instr,              m_instr);
        chk("pc",    PC,                 m_pc);
        chk("pc4",   PC_plus4,           m_pc4);
        chk("err",   32'(addr_err),      32'(m_err));
    endtask

    task automatic tick();
        imem.imem_ack   = ack_force || (m_busy && m_wait >= dly) ||
                          (junk && !m_busy && $urandom_range(0, 3) == 0);
        imem.imem_rdata = m_addr ^ 32'hA5A5_A5A5;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!m_have && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    task automatic go_to(input logic [31:0] target);
        wait_valid("goto_pre");
        jump = 1'b1; PC_J = target;
        tick();
        jump = 1'b0;
        wait_valid("goto_post");
    endtask

    function automatic logic [31:0] rnd_tgt();
        int unsigned r = $urandom_range(0, 15);
        logic [31:0] v = $urandom;
        if (r == 0) return 32'hFFFF_FFFC;
        if (r < 5)  return v;
        return {v[31:2], 2'b00};
    endfunction

    initial begin
        rst_n = 1'b0; stall = 1'b0; jump = 1'b0; jr = 1'b0; branch_taken = 1'b0;
        PC_B = '0; PC_J = '0; PC_R = '0;
        imem.imem_ack = 1'b0; imem.imem_rdata = '0;
        dly = 1; ack_force = 0; junk = 0;
        m_started = 0; m_busy = 0; m_have = 0; m_drop = 0; m_err = 0;
        m_addr = RPC; m_instr = 0; m_pc = RPC; m_pc4 = RPC + 32'd4; m_tgt = 0; m_wait = 0;

        // Reset state
        repeat (2) tick();
        chk("rst_pc4", PC_plus4, RPC + 32'd4);
        chk("rst_req", 32'(imem.imem_req), 32'd0);
        rst_n = 1'b1;

        // Free-running ack one cycle after request
        for (int i = 0; i < 12; i++) begin
            tick();
            if (m_busy && m_wait == 0) seq_q.push_back(imem.imem_addr);
        end
        chk("r018_nreq", 32'(seq_q.size() >= 3), 32'd1);
        for (int i = 0; i < 3 && i < seq_q.size(); i++) chk("r018_seq", seq_q[i], 32'(i * 4));

        // Stall holds the instruction, release fetches PC+4
        go_to(32'h100);
        chk("r019_pc", PC, 32'h100);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("r019_hold_pc", PC, 32'h100);
            chk("r019_hold_instr", instr, 32'h100 ^ 32'hA5A5_A5A5);
        end
        stall = 1'b0;
        tick();
        chk("r019_next", imem.imem_addr, 32'h104);

        // Jump during a slow fetch squashes the stale return
        dly = 4;
        tick();
        tick();
        jump = 1'b1; PC_J = 32'h400;
        tick();
        jump = 1'b0;
        chk("r020_held_addr", imem.imem_addr, 32'h104);
        chk("r020_novalid", 32'(instr_valid), 32'd0);
        wait_valid("r020_valid");
        chk("r020_pc", PC, 32'h400);
        chk("r020_instr", instr, 32'h400 ^ 32'hA5A5_A5A5);
        dly = 1;

        // Priority jump > jr > branch
        jump = 1'b1; jr = 1'b1; branch_taken = 1'b1;
        PC_J = 32'h200; PC_R = 32'h300; PC_B = 32'h500;
        tick();
        jump = 1'b0; jr = 1'b0; branch_taken = 1'b0;
        chk("r021_addr", imem.imem_addr, 32'h200);
        wait_valid("r021_valid");

        // Misaligned branch target
        branch_taken = 1'b1; PC_B = 32'h103;
        tick();
        branch_taken = 1'b0;
        chk("r022_addr", imem.imem_addr, 32'h100);
        chk("r022_err", 32'(addr_err), 32'd1);
        tick();
        chk("r022_err_clr", 32'(addr_err), 32'd0);
        wait_valid("r022_valid");

        // PC+4 wraps at the top of the address space
        go_to(32'hFFFF_FFFC);
        chk("r023_pc4", PC_plus4, 32'h0);
        tick();
        chk("r023_wrap_addr", imem.imem_addr, 32'h0);

        // Reset mid-wait with ack asserted
        dly = 4;
        tick();
        tick();
        ack_force = 1; rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        ack_force = 0;
        chk("r023_rst_addr", imem.imem_addr, RPC);
        chk("r023_rst_req", 32'(imem.imem_req), 32'd1);
        chk("r023_rst_valid", 32'(instr_valid), 32'd0);
        dly = 1;

        // Randomized traffic
        junk = 1;
        for (int i = 0; i < 3000; i++) begin
            int unsigned r = $urandom_range(0, 15);
            stall        = ($urandom_range(0, 2) == 0);
            jump         = (r == 0);
            jr           = (r == 1) || (r == 3);
            branch_taken = (r == 2) || (r == 3) || (r == 4);
            PC_J = rnd_tgt(); PC_R = rnd_tgt(); PC_B = rnd_tgt();
            if ($urandom_range(0, 31) == 0) dly = $urandom_range(0, 3);
            rst_n = ($urandom_range(0, 199) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
